// File: rtl/segre_history_buffer_if.sv
// Bus bundle for segre_history_buffer: allocation, commit and recovery
// requests going in, and pointer status plus the restore-write port coming out.
// Optional statistics outputs are present only when SEGRE_HB_STATS_EN is defined.
interface segre_history_buffer_if #(
  parameter int HB_DEPTH  = 8,
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int ID_SIZE   = $clog2(HB_DEPTH)
);
  logic                 alloc_i;
  logic [REG_SIZE-1:0]  alloc_reg_i;
  logic [WORD_SIZE-1:0] alloc_old_data_i;
  logic [ID_SIZE-1:0]   alloc_id_o;
  logic                 commit_i;
  logic                 recover_i;
  logic [ID_SIZE-1:0]   recover_id_i;
  logic                 full_o;
  logic                 empty_o;
  logic                 busy_o;
  logic                 recovering_o;
  logic [REG_SIZE-1:0]  reg_recovered_o;
  logic [WORD_SIZE-1:0] data_recovered_o;
  logic                 recover_done_o;
`ifdef SEGRE_HB_STATS_EN
  logic [31:0]          recov_count_o;
  logic [31:0]          restored_count_o;
`endif

  modport master (
`ifdef SEGRE_HB_STATS_EN
    input  recov_count_o, restored_count_o,
`endif
    output alloc_i, alloc_reg_i, alloc_old_data_i, commit_i, recover_i, recover_id_i,
    input  alloc_id_o, full_o, empty_o, busy_o, recovering_o, reg_recovered_o,
           data_recovered_o, recover_done_o
  );

  modport slave (
`ifdef SEGRE_HB_STATS_EN
    output recov_count_o, restored_count_o,
`endif
    input  alloc_i, alloc_reg_i, alloc_old_data_i, commit_i, recover_i, recover_id_i,
    output alloc_id_o, full_o, empty_o, busy_o, recovering_o, reg_recovered_o,
           data_recovered_o, recover_done_o
  );
endinterface

// File: rtl/segre_history_buffer.sv
// segre_history_buffer: circular history of {register, old value} pairs.
// Entries are allocated at the tail and retired from the head on commit.
// A recovery walks back from the youngest entry down to the requested id,
// emitting one registered restore write per cycle, youngest first.
// Define SEGRE_HB_STATS_EN to add recovery / restored-entry counters.
module segre_history_buffer #(
  parameter int HB_DEPTH  = 8,
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int ID_SIZE   = $clog2(HB_DEPTH)
) (
  input logic clk_i,
  input logic rst_i,
  segre_history_buffer_if.slave bus
);

  localparam logic [ID_SIZE-1:0] ONE_ID    = 1;
  localparam logic [ID_SIZE:0]   ONE_CNT   = 1;
  localparam logic [ID_SIZE:0]   DEPTH_CNT = (ID_SIZE+1)'(HB_DEPTH);

  typedef enum logic {IDLE, WALK} state_t;

  state_t               state;
  logic [ID_SIZE-1:0]   head;
  logic [ID_SIZE-1:0]   tail;
  logic [ID_SIZE-1:0]   stop;
  logic [ID_SIZE:0]     count;
  logic [REG_SIZE-1:0]  reg_mem  [HB_DEPTH];
  logic [WORD_SIZE-1:0] data_mem [HB_DEPTH];

  logic                 recovering;
  logic                 recover_done;
  logic [REG_SIZE-1:0]  reg_recovered;
  logic [WORD_SIZE-1:0] data_recovered;

  logic [ID_SIZE-1:0]   last;
  logic [ID_SIZE-1:0]   offset;
  logic                 full;
  logic                 empty;
  logic                 rec_live;
  logic                 do_recover;
  logic                 do_alloc;
  logic                 do_commit;

  // Pointer status and request qualification; a live id lies within count of head.
  always_comb begin
    full       = (count == DEPTH_CNT);
    empty      = (count == '0);
    last       = tail - ONE_ID;
    offset     = bus.recover_id_i - head;
    rec_live   = ({1'b0, offset} < count);
    do_recover = (state == IDLE) && bus.recover_i && rec_live;
    do_alloc   = (state == IDLE) && bus.alloc_i && !full && !do_recover;
    do_commit  = (state == IDLE) && bus.commit_i && !empty && !do_recover;
  end

  assign bus.alloc_id_o       = tail;
  assign bus.full_o           = full;
  assign bus.empty_o          = empty;
  assign bus.busy_o           = (state == WALK);
  assign bus.recovering_o     = recovering;
  assign bus.recover_done_o   = recover_done;
  assign bus.reg_recovered_o  = reg_recovered;
  assign bus.data_recovered_o = data_recovered;

  // Entry storage is written on accepted allocations only and is never cleared.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      reg_mem[tail]  <= bus.alloc_reg_i;
      data_mem[tail] <= bus.alloc_old_data_i;
    end
  end

  // Pointer FSM: the first restore is emitted on the accepting edge and the
  // walk leaves WALK on the edge after the entry flagged as done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      head           <= '0;
      tail           <= '0;
      stop           <= '0;
      count          <= '0;
      recovering     <= 1'b0;
      recover_done   <= 1'b0;
      reg_recovered  <= '0;
      data_recovered <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_recover) begin
            state          <= WALK;
            stop           <= bus.recover_id_i;
            recovering     <= 1'b1;
            reg_recovered  <= reg_mem[last];
            data_recovered <= data_mem[last];
            recover_done   <= (last == bus.recover_id_i);
            tail           <= last;
            count          <= count - ONE_CNT;
          end else begin
            recovering     <= 1'b0;
            recover_done   <= 1'b0;
            reg_recovered  <= '0;
            data_recovered <= '0;
            if (do_alloc) tail <= tail + ONE_ID;
            if (do_commit) head <= head + ONE_ID;
            if (do_alloc && !do_commit) count <= count + ONE_CNT;
            else if (!do_alloc && do_commit) count <= count - ONE_CNT;
          end
        end
        WALK: begin
          if (recover_done) begin
            state          <= IDLE;
            recovering     <= 1'b0;
            recover_done   <= 1'b0;
            reg_recovered  <= '0;
            data_recovered <= '0;
          end else begin
            recovering     <= 1'b1;
            reg_recovered  <= reg_mem[last];
            data_recovered <= data_mem[last];
            recover_done   <= (last == stop);
            tail           <= last;
            count          <= count - ONE_CNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEGRE_HB_STATS_EN
  logic [31:0] recov_count;
  logic [31:0] restored_count;

  assign bus.recov_count_o    = recov_count;
  assign bus.restored_count_o = restored_count;

  // Statistics: accepted recoveries and restore writes, both free-running and wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      recov_count    <= '0;
      restored_count <= '0;
    end else begin
      if (do_recover) recov_count <= recov_count + 32'd1;
      if (do_recover || (state == WALK && !recover_done))
        restored_count <= restored_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_segre_history_buffer.sv
// Directed bench for segre_history_buffer. A small model of the buffer
// contents predicts each restore write; predictions are queued when a
// recovery is requested and popped as the restore port produces them.
module tb_segre_history_buffer;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  segre_history_buffer_if #(.HB_DEPTH(DEPTH), .WORD_SIZE(32), .REG_SIZE(5), .ID_SIZE(3)) bus ();

  segre_history_buffer #(.HB_DEPTH(DEPTH), .WORD_SIZE(32), .REG_SIZE(5), .ID_SIZE(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic        last;
  } exp_t;

  exp_t        sbq[$];
  logic [4:0]  m_reg  [DEPTH];
  logic [31:0] m_data [DEPTH];
  int          m_head;
  int          m_tail;
  int          m_count;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  // Compare one observed value against its expectation and keep the tallies.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one cycle of requests, then release them.
  task automatic applyStimulus(input logic alloc, input logic [4:0] r, input logic [31:0] d,
                               input logic commit, input logic recover, input logic [2:0] id);
    bus.alloc_i          = alloc;
    bus.alloc_reg_i      = r;
    bus.alloc_old_data_i = d;
    bus.commit_i         = commit;
    bus.recover_i        = recover;
    bus.recover_id_i     = id;
    tick();
    bus.alloc_i   = 1'b0;
    bus.commit_i  = 1'b0;
    bus.recover_i = 1'b0;
  endtask

  // Predict the effect of one idle-state request on the buffer model.
  task automatic modelStep(input logic alloc, input logic [4:0] r, input logic [31:0] d,
                           input logic commit, input logic recover, input logic [2:0] id);
    int  off;
    int  n;
    int  idx;
    bit  rec_ok;
    bit  a_ok;
    bit  c_ok;
    rec_ok = 1'b0;
    if (recover) begin
      off    = (int'(id) - m_head + DEPTH) % DEPTH;
      rec_ok = (m_count > 0) && (off < m_count);
    end
    if (rec_ok) begin
      n = (m_tail - int'(id) + DEPTH) % DEPTH;
      if (n == 0) n = DEPTH;
      for (int j = 0; j < n; j++) begin
        idx = (m_tail - 1 - j + 2 * DEPTH) % DEPTH;
        sbq.push_back('{r: m_reg[idx], d: m_data[idx], last: (j == n - 1)});
      end
      m_tail  = int'(id);
      m_count = m_count - n;
    end else begin
      a_ok = alloc && (m_count < DEPTH);
      c_ok = commit && (m_count > 0);
      if (a_ok) begin
        m_reg[m_tail]  = r;
        m_data[m_tail] = d;
        m_tail         = (m_tail + 1) % DEPTH;
        m_count++;
      end
      if (c_ok) begin
        m_head = (m_head + 1) % DEPTH;
        m_count--;
      end
    end
  endtask

  task automatic step(input logic alloc, input logic [4:0] r, input logic [31:0] d,
                      input logic commit, input logic recover, input logic [2:0] id);
    modelStep(alloc, r, d, commit, recover, id);
    applyStimulus(alloc, r, d, commit, recover, id);
  endtask

  task automatic doReset;
    rst                  = 1'b1;
    bus.alloc_i          = 1'b0;
    bus.alloc_reg_i      = '0;
    bus.alloc_old_data_i = '0;
    bus.commit_i         = 1'b0;
    bus.recover_i        = 1'b0;
    bus.recover_id_i     = '0;
    tick();
    tick();
    rst     = 1'b0;
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    sbq.delete();
  endtask

  // Follow a restore walk, popping one prediction per restore cycle.
  task automatic checkWalk(input string tag, input bit alloc_during);
    int   budget;
    exp_t e;
    budget = 20;
    while (sbq.size() > 0 && budget > 0) begin
      checkOutput({tag, "_recovering"}, 32'(bus.recovering_o), 32'd1);
      checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
      if (bus.recovering_o) begin
        e = sbq.pop_front();
        checkOutput({tag, "_reg"}, 32'(bus.reg_recovered_o), 32'(e.r));
        checkOutput({tag, "_data"}, bus.data_recovered_o, e.d);
        checkOutput({tag, "_done"}, 32'(bus.recover_done_o), 32'(e.last));
      end
      budget--;
      if (alloc_during) applyStimulus(1'b1, 5'd31, 32'hDEAD, 1'b0, 1'b0, 3'd0);
      else tick();
    end
    if (budget == 0) checkOutput({tag, "_timeout_left"}, 32'(sbq.size()), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(bus.busy_o), 32'd0);
    checkOutput({tag, "_recovering_after"}, 32'(bus.recovering_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    doReset();

    // Reset state.
    checkOutput("rst_empty", 32'(bus.empty_o), 32'd1);
    checkOutput("rst_full", 32'(bus.full_o), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rst_alloc_id", 32'(bus.alloc_id_o), 32'd0);
    checkOutput("rst_recovering", 32'(bus.recovering_o), 32'd0);
    checkOutput("rst_done", 32'(bus.recover_done_o), 32'd0);
    checkOutput("rst_reg", 32'(bus.reg_recovered_o), 32'd0);
    checkOutput("rst_data", bus.data_recovered_o, 32'd0);

    // Fill, drop an overflow alloc, then restore every entry.
    for (int r = 1; r <= 8; r++) step(1'b1, 5'(r), 32'h100 + 32'(r), 1'b0, 1'b0, 3'd0);
    checkOutput("fill_full", 32'(bus.full_o), 32'd1);
    checkOutput("fill_empty", 32'(bus.empty_o), 32'd0);
    checkOutput("fill_alloc_id", 32'(bus.alloc_id_o), 32'd0);
    step(1'b1, 5'd9, 32'h109, 1'b0, 1'b0, 3'd0);
    checkOutput("ovf_full", 32'(bus.full_o), 32'd1);
    checkOutput("ovf_alloc_id", 32'(bus.alloc_id_o), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0);
    checkWalk("full_walk", 1'b0);
    checkOutput("full_walk_empty", 32'(bus.empty_o), 32'd1);

    // Short recovery to id 1 of three entries.
    doReset();
    for (int r = 3; r <= 5; r++) step(1'b1, 5'(r), 32'h300 + 32'(r), 1'b0, 1'b0, 3'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd1);
    checkWalk("walk2", 1'b0);
    checkOutput("walk2_alloc_id", 32'(bus.alloc_id_o), 32'd1);
`ifdef SEGRE_HB_STATS_EN
    checkOutput("stats_recov", bus.recov_count_o, 32'd1);
    checkOutput("stats_restored", bus.restored_count_o, 32'd2);
`endif

    // Non-live recovery is ignored; allocs during a walk are ignored.
    doReset();
    for (int r = 10; r <= 12; r++) step(1'b1, 5'(r), 32'hA00 + 32'(r), 1'b0, 1'b0, 3'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd5);
    checkOutput("nonlive_recovering", 32'(bus.recovering_o), 32'd0);
    checkOutput("nonlive_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("nonlive_alloc_id", 32'(bus.alloc_id_o), 32'd3);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0);
    checkWalk("walk_alloc", 1'b1);
    checkOutput("walk_alloc_id", 32'(bus.alloc_id_o), 32'd0);
    checkOutput("walk_alloc_empty", 32'(bus.empty_o), 32'd1);

    // Wrap-around recovery across the end of storage.
    doReset();
    for (int r = 1; r <= 6; r++) step(1'b1, 5'(r), 32'h500 + 32'(r), 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 3'd0);
    checkOutput("wrap_empty", 32'(bus.empty_o), 32'd1);
    checkOutput("wrap_alloc_id6", 32'(bus.alloc_id_o), 32'd6);
    for (int r = 20; r <= 23; r++) step(1'b1, 5'(r), 32'h2000 + 32'(r), 1'b0, 1'b0, 3'd0);
    checkOutput("wrap_alloc_id2", 32'(bus.alloc_id_o), 32'd2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd7);
    checkWalk("wrap_walk", 1'b0);
    checkOutput("wrap_after_id", 32'(bus.alloc_id_o), 32'd7);

    // Simultaneous alloc+commit, then recover with a same-cycle alloc.
    doReset();
    step(1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 3'd0);
    step(1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 3'd0);
    step(1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 3'd0);
    checkOutput("ac_alloc_id", 32'(bus.alloc_id_o), 32'd3);
    checkOutput("ac_empty", 32'(bus.empty_o), 32'd0);
    checkOutput("ac_full", 32'(bus.full_o), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd1);
    checkWalk("ac_walk", 1'b0);
    checkOutput("ac_walk_id", 32'(bus.alloc_id_o), 32'd1);
    checkOutput("ac_walk_empty", 32'(bus.empty_o), 32'd1);
    step(1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 3'd0);
    step(1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 3'd1);
    checkWalk("ra_walk", 1'b0);
    checkOutput("ra_alloc_id", 32'(bus.alloc_id_o), 32'd1);
    checkOutput("ra_empty", 32'(bus.empty_o), 32'd1);

    // Reset in the second cycle of a four-entry walk.
    doReset();
    for (int r = 4; r <= 7; r++) step(1'b1, 5'(r), 32'h700 + 32'(r), 1'b0, 1'b0, 3'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0);
    e = sbq.pop_front();
    checkOutput("mr_rec1", 32'(bus.recovering_o), 32'd1);
    checkOutput("mr_reg1", 32'(bus.reg_recovered_o), 32'(e.r));
    tick();
    e = sbq.pop_front();
    checkOutput("mr_rec2", 32'(bus.recovering_o), 32'd1);
    checkOutput("mr_reg2", 32'(bus.reg_recovered_o), 32'(e.r));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbq.delete();
    checkOutput("mr_recovering", 32'(bus.recovering_o), 32'd0);
    checkOutput("mr_empty", 32'(bus.empty_o), 32'd1);
    checkOutput("mr_busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mr_no_done", 32'(bus.recover_done_o), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/segre_history_buffer.md
# segre_history_buffer

Circular history buffer that restores the register file after a flush. On each architectural register write it records the destination register and its old value, and retires entries in order at commit. On a recovery request it walks back from the youngest entry to the flush point, emitting one restore write per cycle on the register file's recovery port (`recovering`, `reg_recovered`, `data_recovered`).

## Interface
- `HB_DEPTH`, 8, number of entries; power of two, ≥2
- `WORD_SIZE`, 32, data width
- `REG_SIZE`, 5, register index width
- `ID_SIZE`, $clog2(HB_DEPTH), entry id width

- `clk_i` in 1: clock; single clock domain
- `rst_i` in 1: reset, synchronous, active-high
- `alloc_i` in 1: record a register write
- `alloc_reg_i` in REG_SIZE: destination register of the write
- `alloc_old_data_i` in WORD_SIZE: value of `alloc_reg_i` before the write
- `alloc_id_o` out ID_SIZE: id the next allocation receives (current tail)
- `commit_i` in 1: retire the oldest entry
- `recover_i` in 1: start recovery
- `recover_id_i` in ID_SIZE: oldest entry to undo; must be live
- `full_o` out 1: count == HB_DEPTH
- `empty_o` out 1: count == 0
- `busy_o` out 1: FSM in WALK
- `recovering_o` out 1: restore write valid this cycle
- `reg_recovered_o` out REG_SIZE: register being restored
- `data_recovered_o` out WORD_SIZE: value being restored
- `recover_done_o` out 1: one-cycle pulse with the last restore write

## Operation
- State: `head` (oldest), `tail` (next free), both ID_SIZE bits with modular wrap; `count` is ID_SIZE+1 bits, range 0..HB_DEPTH.
- Live entries are `head` up to `tail-1`, taken modulo HB_DEPTH.
- FSM states:
  - IDLE: accepts alloc, commit and recover.
  - WALK: restore walk in progress.
- IDLE behaviour:
  - `alloc_i` with `!full_o`: writes {reg, old_data} at `tail`; `tail++`; `count++`. `alloc_i` while full is dropped with no state change.
  - `commit_i` with `!empty_o`: `head++`; `count--`. Commit while empty is ignored.
  - Alloc and commit in the same cycle both take effect; `count` is unchanged. When full, the alloc is still dropped.
  - `recover_i` with `recover_id_i` live: latches `stop = recover_id_i` and enters WALK. Any same-cycle alloc or commit is dropped.
  - `recover_i` with a non-live id, or while empty, is ignored.
- WALK behaviour, per cycle:
  - Outputs entry `tail-1`; then `tail--` and `count--`.
  - When `tail-1 == stop`, asserts `recover_done_o` and returns to IDLE.
  - `alloc_i`, `commit_i` and `recover_i` are ignored.
- Restored entries are N = (tail − recover_id_i) mod HB_DEPTH, or HB_DEPTH when the buffer is full and `recover_id_i == head`.
- Entries for x0 are emitted unchanged; the register file discards them.

## Timing
- Reset values: `head = tail = count = 0`; IDLE; `full_o = 0`, `empty_o = 1`, `busy_o = 0`. `recovering_o`, `recover_done_o`, `reg_recovered_o` and `data_recovered_o` are all 0. Entry storage is not reset.
- `alloc_id_o`, `full_o`, `empty_o` and `busy_o` are combinational from registered state.
- Restore outputs are registered. For `recover_i` sampled at edge k, `recovering_o` is high for cycles k+1..k+N and `recover_done_o` is high in cycle k+N.
- Restore order is youngest first, so the oldest value of any register is written last.
- `busy_o` is high in cycles k+1..k+N. An alloc is accepted again at edge k+N+1.
- An alloc at edge k becomes readable by a WALK starting at edge k+1.
- Reset asserted mid-walk: at the next edge the block is IDLE and empty, and `recovering_o` is 0 from that cycle. Remaining restores are abandoned.

## Configuration
- `SEGRE_HB_STATS_EN`
  - Defined: adds outputs `recov_count_o` and `restored_count_o`, both 32 bits and both cleared on reset. `recov_count_o` increments per accepted recovery. `restored_count_o` increments per cycle with `recovering_o` high. Both wrap at 2^32.
  - Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then 8 allocs (regs 1..8, old data 0x100+reg) → `full_o` = 1 after the 8th. A 9th alloc is dropped and `alloc_id_o` stays 0.
- Allocs to regs 3, 4, 5 (ids 0..2), then `recover_i` with id 1 at edge k → cycle k+1 restores reg 5, cycle k+2 restores reg 4 with `recover_done_o` high. Afterwards `alloc_id_o` = 1 and `busy_o` = 0 in cycle k+3.
- Wrap: 6 allocs, 6 commits, then 4 allocs (ids 6, 7, 0, 1), then recover id 7 → restores ids 1, 0, 7 in that order over 3 cycles.
- Alloc and commit in the same cycle, with `count` = 2 → `count` stays 2 and `head` and `tail` each advance by 1. `recover_i` together with `alloc_i` → the alloc is dropped.
- `recover_i` with a non-live id (id 5, live ids 0..2) → ignored, `recovering_o` stays 0. `alloc_i` during WALK → ignored.
- Reset asserted in the 2nd cycle of a 4-entry walk → next cycle `recovering_o` = 0, `empty_o` = 1, `recover_done_o` never pulses.
